// File: rtl/divider_seq_if.sv
// Handshake and data bundle for divider_seq: start/mode/operands in, results/status out.
interface divider_seq_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_DIV;
  logic             signed_mode;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_quotient;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_DIV, signed_mode, data_operandA, data_operandB,
    input  data_quotient, data_remainder, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_DIV, signed_mode, data_operandA, data_operandB,
    output data_quotient, data_remainder, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/divider_seq.sv
// Multi-cycle signed/unsigned integer divider, one non-restoring step per clock.
module divider_seq #(
  parameter int WIDTH = 32
) (
  input logic          clock,
  input logic          reset,
  divider_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH:0]   pr, pr_nxt;
  logic [WIDTH-1:0]   mag_b, mag_b_nxt;
  logic [WIDTH-1:0]   a_raw, a_raw_nxt;
  logic               sq, sq_nxt, sr, sr_nxt, div0, div0_nxt;
  logic [CW-1:0]      count, count_nxt;
  logic [WIDTH-1:0]   quot, quot_nxt, rem, rem_nxt;
  logic               exc, exc_nxt, rdy, rdy_nxt;

  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH:0]     hi, hi_new, rem_fix;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      pr    <= '0;
      mag_b <= '0;
      a_raw <= '0;
      sq    <= 1'b0;
      sr    <= 1'b0;
      div0  <= 1'b0;
      count <= '0;
      quot  <= '0;
      rem   <= '0;
      exc   <= 1'b0;
      rdy   <= 1'b0;
    end else begin
      state <= state_nxt;
      pr    <= pr_nxt;
      mag_b <= mag_b_nxt;
      a_raw <= a_raw_nxt;
      sq    <= sq_nxt;
      sr    <= sr_nxt;
      div0  <= div0_nxt;
      count <= count_nxt;
      quot  <= quot_nxt;
      rem   <= rem_nxt;
      exc   <= exc_nxt;
      rdy   <= rdy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pr_nxt    = pr;
    mag_b_nxt = mag_b;
    a_raw_nxt = a_raw;
    sq_nxt    = sq;
    sr_nxt    = sr;
    div0_nxt  = div0;
    count_nxt = count;
    quot_nxt  = quot;
    rem_nxt   = rem;
    exc_nxt   = exc;
    rdy_nxt   = 1'b0;
    sa        = bus.signed_mode & bus.data_operandA[WIDTH-1];
    sb        = bus.signed_mode & bus.data_operandB[WIDTH-1];
    mag_a     = sa ? -bus.data_operandA : bus.data_operandA;
    hi        = pr[2*WIDTH-1:WIDTH-1];
    hi_new    = pr[2*WIDTH] ? hi + {1'b0, mag_b} : hi - {1'b0, mag_b};
    rem_fix   = pr[2*WIDTH] ? pr[2*WIDTH:WIDTH] + {1'b0, mag_b} : pr[2*WIDTH:WIDTH];

    // A start pulse wins over any in-flight state, silently abandoning it.
    if (bus.ctrl_DIV) begin
      a_raw_nxt = bus.data_operandA;
      mag_b_nxt = sb ? -bus.data_operandB : bus.data_operandB;
      sq_nxt    = sa ^ sb;
      sr_nxt    = sa;
      div0_nxt  = (bus.data_operandB == '0);
      pr_nxt    = {{(WIDTH+1){1'b0}}, mag_a};
      count_nxt = '0;
      state_nxt = (bus.data_operandB == '0) ? FIX : RUN;
    end else begin
      case (state)
        RUN: begin
          // Remainder stays within (-|B|, |B|), so W+1 bits wrap harmlessly.
          pr_nxt    = {hi_new, pr[WIDTH-2:0], ~hi_new[WIDTH]};
          count_nxt = count + 1'b1;
          if (count == CW'(WIDTH-1)) state_nxt = FIX;
        end
        FIX: begin
          quot_nxt  = div0 ? '1    : (sq ? -pr[WIDTH-1:0] : pr[WIDTH-1:0]);
          rem_nxt   = div0 ? a_raw : (sr ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0]);
          exc_nxt   = div0;
          rdy_nxt   = 1'b1;
          state_nxt = IDLE;
        end
        default: ;
      endcase
    end
  end

  assign bus.data_quotient  = quot;
  assign bus.data_remainder = rem;
  assign bus.data_exception = exc;
  assign bus.data_resultRDY = rdy;
  assign bus.busy           = (state != IDLE);
endmodule
